mem_port_scheduler: RTL and testbench
=====================================

Name: mem_port_scheduler

Overview:
- Shares the single L2 memory port between three requesters: icache (read), dcache (read/write) and a next-line prefetcher (read).
- Sits between the L1 caches/prefetcher and the L2 cache.
- Latches one request at a time, holds it stable on the pmem port until pmem_resp, then routes the response back to its owner.
- Arbitration: dcache has priority; icache ages out of starvation; prefetch is served only when the port is otherwise idle.

Parameters:
- STARVE_LIMIT, 4: consecutive icache arbitration losses before icache is forced to win. 0 disables aging (pure dcache priority).
- CNT_W, 32: width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- d_read  in  1  dcache read request
- d_write  in  1  dcache write request
- d_addr  in  32  dcache line address
- d_wdata  in  256  dcache write line
- d_resp  out  1  dcache transaction done
- d_rdata  out  256  dcache read line
- i_read  in  1  icache read request
- i_addr  in  32  icache line address
- i_resp  out  1  icache transaction done
- i_rdata  out  256  icache read line
- pf_read  in  1  prefetch read request
- pf_addr  in  32  prefetch line address
- pf_resp  out  1  prefetch done
- pf_rdata  out  256  prefetch read line
- pmem_read  out  1  L2 read strobe
- pmem_write  out  1  L2 write strobe
- pmem_addr  out  32  L2 address
- pmem_wdata  out  256  L2 write line
- pmem_rdata  in  256  L2 read line
- pmem_resp  in  1  L2 done
- perf_d_grants, perf_i_grants, perf_pf_grants, perf_stall_cycles  out  CNT_W each  counters (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; owner=NONE; starve_cnt=0.
  - All pmem_* outputs 0; all *_resp outputs 0.
  - A transaction in flight is abandoned; any late pmem_resp after reset release is ignored while in IDLE.
- States: IDLE, BUSY, RECOVER.
- IDLE, arbitration, evaluated every cycle. Priority order:
  1. icache if i_read and STARVE_LIMIT>0 and starve_cnt==STARVE_LIMIT;
  2. dcache if d_read|d_write;
  3. icache if i_read;
  4. prefetch if pf_read.
- IDLE, on grant:
  - Register owner, address, write flag, wdata; go to BUSY.
  - pmem_read/pmem_write assert the cycle after the request is seen (1-cycle grant latency).
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) when dcache wins while i_read is asserted.
  - Clears to 0 on any icache grant.
  - Held otherwise.
- dcache d_read and d_write both high: write wins (pmem_write=1, pmem_read=0).
- BUSY:
  - pmem_read/write/addr/wdata held constant from latched values regardless of requester inputs.
  - On pmem_resp=1: owner's *_resp=1 combinationally in the same cycle, owner's *_rdata=pmem_rdata, pmem_read/write drop next cycle; go to RECOVER.
- Non-owner *_resp always 0. *_rdata for every requester is driven from pmem_rdata (only the resp is qualified).
- RECOVER:
  - One cycle, no grant, all pmem strobes 0. Lets the owner deassert its request so it is not re-granted.
  - Go to IDLE.
- Back-to-back throughput: minimum 3 cycles between successive pmem strobes (BUSY ≥1 cycle, RECOVER, IDLE grant).
- Requester dropping its request while BUSY: transaction still completes; resp still pulses.
- pmem_resp outside BUSY: ignored.

Optional Feature:
- Macro: SCHED_PERF_CNT_EN.
- Defined:
  - perf_d_grants, perf_i_grants and perf_pf_grants each increment by 1 per grant to that requester.
  - perf_stall_cycles increments each cycle any request is pending but not granted (BUSY, RECOVER, or losing arbitration).
  - All counters wrap at 2^CNT_W and reset to 0.
- Not defined: counter registers absent; all perf_* outputs tied to 0.

Test Plan:
- Reset, then i_read=1, i_addr=0x0000_1000 → pmem_read=1, pmem_addr=0x1000 next cycle; L2 returns resp after 5 cycles with rdata=0xA5..A5 → i_resp=1 and i_rdata=0xA5..A5 same cycle; d_resp and pf_resp stay 0.
- d_read and i_read both high from the same cycle, STARVE_LIMIT=4, requests reasserted after each resp → dcache granted 4 times, 5th grant goes to icache; starve_cnt reads 0 afterwards.
- d_write=1, d_addr=0x2000, d_wdata=0x1234..; d_addr changed to 0x3000 mid-BUSY → pmem_write=1 with pmem_addr=0x2000 and original wdata held until pmem_resp.
- pf_read=1 with i_read and d_read low → prefetch granted. pf_read and i_read both high → icache granted first; prefetch granted only after icache completes and the RECOVER cycle passes.
- rst pulsed low during BUSY → pmem_read=0 immediately (async); pmem_resp=1 arriving after release → no *_resp asserted; state IDLE.
- With SCHED_PERF_CNT_EN: 3 dcache grants, 1 icache grant, 6 stalled cycles → perf_d_grants=3, perf_i_grants=1, perf_stall_cycles=6. Without the macro: all perf_* outputs 0.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: shares one L2 port between dcache, icache and next-line prefetcher.
// Optional performance counters are built when SCHED_PERF_CNT_EN is defined.
module mem_port_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  // dcache
  input  logic               d_read,
  input  logic               d_write,
  input  logic [31:0]        d_addr,
  input  logic [255:0]       d_wdata,
  output logic               d_resp,
  output logic [255:0]       d_rdata,
  // icache
  input  logic               i_read,
  input  logic [31:0]        i_addr,
  output logic               i_resp,
  output logic [255:0]       i_rdata,
  // prefetcher
  input  logic               pf_read,
  input  logic [31:0]        pf_addr,
  output logic               pf_resp,
  output logic [255:0]       pf_rdata,
  // L2 port
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_addr,
  output logic [255:0]       pmem_wdata,
  input  logic [255:0]       pmem_rdata,
  input  logic               pmem_resp,
  // performance counters
  output logic [CNT_W-1:0]   perf_d_grants,
  output logic [CNT_W-1:0]   perf_i_grants,
  output logic [CNT_W-1:0]   perf_pf_grants,
  output logic [CNT_W-1:0]   perf_stall_cycles
);

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam bit          AGING_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RECOVER} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I, OWN_PF} owner_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              grant_own;
  req_t                req_q, req_d;
  logic                pmem_read_q, pmem_read_d;
  logic                pmem_write_q, pmem_write_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                grant_fire;
  logic                starve_hit;
  logic                busy_resp;

  // Fixed-priority pick with icache aging on top
  always_comb begin
    grant_own  = OWN_NONE;
    starve_hit = AGING_EN && (starve_q == STARVE_W'(STARVE_LIMIT));
    if (i_read && starve_hit) begin
      grant_own = OWN_I;
    end else if (d_read || d_write) begin
      grant_own = OWN_D;
    end else if (i_read) begin
      grant_own = OWN_I;
    end else if (pf_read) begin
      grant_own = OWN_PF;
    end
  end

  assign grant_fire = (state_q == ST_IDLE) && (grant_own != OWN_NONE);

  // Next-state and latched-request logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_d        = req_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          state_d = ST_BUSY;
          owner_d = grant_own;
          case (grant_own)
            OWN_D: begin
              req_d.wr    = d_write;
              req_d.addr  = d_addr;
              req_d.wdata = d_wdata;
            end
            OWN_I: begin
              req_d.wr    = 1'b0;
              req_d.addr  = i_addr;
              req_d.wdata = '0;
            end
            default: begin
              req_d.wr    = 1'b0;
              req_d.addr  = pf_addr;
              req_d.wdata = '0;
            end
          endcase
          pmem_read_d  = ~req_d.wr;
          pmem_write_d = req_d.wr;
        end
      end
      ST_BUSY: begin
        if (pmem_resp) begin
          state_d      = ST_RECOVER;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d      = ST_IDLE;
        owner_d      = OWN_NONE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // Icache loss counter: saturates at the limit, cleared by any icache win
  always_comb begin
    starve_d = starve_q;
    if (grant_fire) begin
      if (grant_own == OWN_I) begin
        starve_d = '0;
      end else if (grant_own == OWN_D && i_read && !starve_hit && AGING_EN) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      req_q        <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      req_q        <= req_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      starve_q     <= starve_d;
    end
  end

  assign pmem_read  = pmem_read_q;
  assign pmem_write = pmem_write_q;
  assign pmem_addr  = req_q.addr;
  assign pmem_wdata = req_q.wdata;

  // Completion is steered to the owner in the same cycle as pmem_resp
  assign busy_resp = (state_q == ST_BUSY) && pmem_resp;
  assign d_resp    = busy_resp && (owner_q == OWN_D);
  assign i_resp    = busy_resp && (owner_q == OWN_I);
  assign pf_resp   = busy_resp && (owner_q == OWN_PF);
  assign d_rdata   = pmem_rdata;
  assign i_rdata   = pmem_rdata;
  assign pf_rdata  = pmem_rdata;

`ifdef SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] perf_d_q, perf_i_q, perf_pf_q, perf_stall_q;
  logic             d_pend;
  logic             stall_c;

  // A cycle stalls when some pending requester is not the one being granted
  always_comb begin
    d_pend  = d_read || d_write;
    stall_c = 1'b0;
    if (state_q != ST_IDLE) begin
      stall_c = d_pend || i_read || pf_read;
    end else begin
      stall_c = (d_pend  && (grant_own != OWN_D)) ||
                (i_read  && (grant_own != OWN_I)) ||
                (pf_read && (grant_own != OWN_PF));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_d_q     <= '0;
      perf_i_q     <= '0;
      perf_pf_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (grant_fire && grant_own == OWN_D)  perf_d_q  <= perf_d_q + CNT_W'(1);
      if (grant_fire && grant_own == OWN_I)  perf_i_q  <= perf_i_q + CNT_W'(1);
      if (grant_fire && grant_own == OWN_PF) perf_pf_q <= perf_pf_q + CNT_W'(1);
      if (stall_c) perf_stall_q <= perf_stall_q + CNT_W'(1);
    end
  end

  assign perf_d_grants     = perf_d_q;
  assign perf_i_grants     = perf_i_q;
  assign perf_pf_grants    = perf_pf_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_d_grants     = '0;
  assign perf_i_grants     = '0;
  assign perf_pf_grants    = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Self-checking bench for mem_port_scheduler: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_port_scheduler;

  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         d_read = 1'b0, d_write = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [255:0] d_wdata = '0;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         i_read = 1'b0;
  logic [31:0]  i_addr = '0;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         pf_read = 1'b0;
  logic [31:0]  pf_addr = '0;
  logic         pf_resp;
  logic [255:0] pf_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [31:0]  perf_d_grants, perf_i_grants, perf_pf_grants, perf_stall_cycles;

  int errors = 0;
  int checks = 0;

  mem_port_scheduler #(.STARVE_LIMIT(LIM), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .pf_read(pf_read), .pf_addr(pf_addr), .pf_resp(pf_resp), .pf_rdata(pf_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .perf_d_grants(perf_d_grants), .perf_i_grants(perf_i_grants),
    .perf_pf_grants(perf_pf_grants), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dr, dw, ir, pr;
    int   own;   // 0 none, 1 dcache, 2 icache, 3 prefetch
    logic wr;
  } vec_t;

  localparam logic [31:0] D_A = 32'h0000_2000;
  localparam logic [31:0] I_A = 32'h0000_1000;
  localparam logic [31:0] P_A = 32'h0000_4000;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] addr_of(input int own);
    return (own == 1) ? D_A : (own == 2) ? I_A : P_A;
  endfunction

  task automatic clear_reqs();
    d_read = 1'b0; d_write = 1'b0; i_read = 1'b0; pf_read = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_reqs();
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    d_addr = D_A; i_addr = I_A; pf_addr = P_A; d_wdata = {8{32'h1234_5678}};
  endtask

  // Wait for the strobe, check the held request for lat cycles while the requesters'
  // address/data inputs are disturbed, then complete it and check the RECOVER cycle.
  task automatic run_txn(input int own, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input int lat, input int exp_wait,
                         input bit drop);
    int w;
    logic [31:0]  sd, si, sp;
    logic [255:0] sw, rd;
    sd = d_addr; si = i_addr; sp = pf_addr; sw = d_wdata; w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(pmem_read || pmem_write) && w < 8);
    chk("grant_latency", 256'(w), 256'(exp_wait));
    if (drop) clear_reqs();
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      chk("busy_read", 256'(pmem_read), 256'(!wr));
      chk("busy_write", 256'(pmem_write), 256'(wr));
      chk("busy_addr", 256'(pmem_addr), 256'(addr));
      if (wr) chk("busy_wdata", pmem_wdata, wdata);
      d_addr = sd ^ 32'h0000_1000; i_addr = si ^ 32'h0000_1000;
      pf_addr = sp ^ 32'h0000_1000; d_wdata = ~sw;
    end
    d_addr = sd; i_addr = si; pf_addr = sp; d_wdata = sw;
    rd = rnd256();
    pmem_rdata = rd;
    pmem_resp = 1'b1;
    #1;
    chk("d_resp", 256'(d_resp), 256'(own == 1));
    chk("i_resp", 256'(i_resp), 256'(own == 2));
    chk("pf_resp", 256'(pf_resp), 256'(own == 3));
    chk("d_rdata", d_rdata, rd);
    chk("i_rdata", i_rdata, rd);
    chk("pf_rdata", pf_rdata, rd);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("recover_strobes", 256'({pmem_read, pmem_write}), 256'(0));
  endtask

  // Reference model state (transaction level)
  bit           m_valid;
  int           m_own;
  logic         m_wr;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  int           m_free_at, m_starve, m_cyc;
  int           m_dg, m_ig, m_pg, m_st;

  function automatic int pick(input logic dp, input logic ir, input logic pr, input int starve);
    if (ir && LIM > 0 && starve == LIM) return 2;
    if (dp) return 1;
    if (ir) return 2;
    if (pr) return 3;
    return 0;
  endfunction

  vec_t vecs[9];
  logic [31:0] perf_exp [4];

  initial begin
    vecs[0] = '{1, 0, 0, 0, 1, 0};
    vecs[1] = '{0, 1, 0, 0, 1, 1};
    vecs[2] = '{1, 1, 0, 0, 1, 1};
    vecs[3] = '{0, 0, 1, 0, 2, 0};
    vecs[4] = '{0, 0, 0, 1, 3, 0};
    vecs[5] = '{1, 0, 1, 0, 1, 0};
    vecs[6] = '{0, 0, 1, 1, 2, 0};
    vecs[7] = '{1, 0, 1, 1, 1, 0};
    vecs[8] = '{0, 0, 0, 0, 0, 0};

    // Reset state, with requests and a stray pmem_resp present
    #2 rst = 1'b0;
    d_read = 1'b1; i_read = 1'b1; pf_read = 1'b1; pmem_resp = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pmem_read", 256'(pmem_read), 256'(0));
    chk("rst_pmem_write", 256'(pmem_write), 256'(0));
    chk("rst_pmem_addr", 256'(pmem_addr), 256'(0));
    chk("rst_pmem_wdata", pmem_wdata, 256'(0));
    chk("rst_resps", 256'({d_resp, i_resp, pf_resp}), 256'(0));
    chk("rst_perf", 256'({perf_d_grants, perf_i_grants, perf_pf_grants, perf_stall_cycles}), 256'(0));

    // Arbitration vectors, one transaction each from a fresh reset
    for (int v = 0; v < 9; v++) begin
      do_reset();
      d_read = vecs[v].dr; d_write = vecs[v].dw; i_read = vecs[v].ir; pf_read = vecs[v].pr;
      if (vecs[v].own == 0) begin
        pmem_resp = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          #1;
          chk("idle_strobes", 256'({pmem_read, pmem_write}), 256'(0));
          chk("idle_resps", 256'({d_resp, i_resp, pf_resp}), 256'(0));
        end
        pmem_resp = 1'b0;
      end else begin
        run_txn(vecs[v].own, vecs[v].wr, addr_of(vecs[v].own), d_wdata, 1, 1, 1'b0);
      end
      clear_reqs();
    end

    // icache read with 5-cycle L2 latency; requester drops its request while busy
    do_reset();
    i_read = 1'b1;
    run_txn(2, 1'b0, I_A, '0, 4, 1, 1'b1);

    // Starvation aging: four dcache wins then icache, twice over
    do_reset();
    d_read = 1'b1; i_read = 1'b1;
    for (int n = 0; n < 10; n++)
      run_txn((n % 5 == 4) ? 2 : 1, 1'b0, (n % 5 == 4) ? I_A : D_A, '0, 1, (n == 0) ? 1 : 2, 1'b0);
    clear_reqs();

    // Write held stable while dcache inputs move
    do_reset();
    d_write = 1'b1;
    run_txn(1, 1'b1, D_A, {8{32'h1234_5678}}, 3, 1, 1'b0);
    clear_reqs();

    // icache beats prefetch; prefetch follows after RECOVER
    do_reset();
    i_read = 1'b1; pf_read = 1'b1;
    run_txn(2, 1'b0, I_A, '0, 1, 1, 1'b0);
    i_read = 1'b0;
    run_txn(3, 1'b0, P_A, '0, 1, 2, 1'b0);
    clear_reqs();

    // Async reset in mid-transaction; a late pmem_resp must be ignored
    do_reset();
    d_read = 1'b1;
    @(negedge clk);
    chk("pre_rst_read", 256'(pmem_read), 256'(1));
    #2 rst = 1'b0;
    #1 chk("async_rst_read", 256'(pmem_read), 256'(0));
    clear_reqs();
    @(negedge clk);
    rst = 1'b1;
    pmem_resp = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("late_resp", 256'({d_resp, i_resp, pf_resp}), 256'(0));
      @(negedge clk);
      chk("late_strobes", 256'({pmem_read, pmem_write}), 256'(0));
    end
    pmem_resp = 1'b0;

    // Randomized run against the reference model
    do_reset();
    m_valid = 0; m_free_at = 0; m_starve = 0; m_cyc = 0;
    m_dg = 0; m_ig = 0; m_pg = 0; m_st = 0;
    for (int n = 0; n < 3000; n++) begin
      int  own;
      bit  idle, dp;
      chk("rnd_read", 256'(pmem_read), 256'(m_valid && !m_wr));
      chk("rnd_write", 256'(pmem_write), 256'(m_valid && m_wr));
      if (m_valid) chk("rnd_addr", 256'(pmem_addr), 256'(m_addr));
      if (m_valid && m_wr) chk("rnd_wdata", pmem_wdata, m_wdata);
      d_read  = ($urandom_range(0, 99) < 40);
      d_write = ($urandom_range(0, 99) < 20);
      i_read  = ($urandom_range(0, 99) < 55);
      pf_read = ($urandom_range(0, 99) < 35);
      d_addr = $urandom; i_addr = $urandom; pf_addr = $urandom;
      d_wdata = rnd256(); pmem_rdata = rnd256();
      pmem_resp = ($urandom_range(0, 2) == 0);
      #1;
      chk("rnd_d_resp", 256'(d_resp), 256'(m_valid && pmem_resp && m_own == 1));
      chk("rnd_i_resp", 256'(i_resp), 256'(m_valid && pmem_resp && m_own == 2));
      chk("rnd_pf_resp", 256'(pf_resp), 256'(m_valid && pmem_resp && m_own == 3));
      chk("rnd_d_rdata", d_rdata, pmem_rdata);
      dp = d_read || d_write;
      idle = !m_valid && (m_cyc >= m_free_at);
      own = idle ? pick(dp, i_read, pf_read, m_starve) : 0;
      if ((dp && own != 1) || (i_read && own != 2) || (pf_read && own != 3)) m_st++;
      if (m_valid) begin
        if (pmem_resp) begin
          m_valid = 0;
          m_free_at = m_cyc + 2;
        end
      end else if (own != 0) begin
        m_valid = 1;
        m_own = own;
        m_wr = (own == 1) && d_write;
        m_addr = (own == 1) ? d_addr : (own == 2) ? i_addr : pf_addr;
        m_wdata = d_wdata;
        if (own == 1) m_dg++;
        if (own == 2) m_ig++;
        if (own == 3) m_pg++;
        if (own == 2) m_starve = 0;
        else if (own == 1 && i_read && m_starve < LIM) m_starve++;
      end
      m_cyc++;
      @(negedge clk);
    end
`ifdef SCHED_PERF_CNT_EN
    perf_exp[0] = m_dg; perf_exp[1] = m_ig; perf_exp[2] = m_pg; perf_exp[3] = m_st;
`else
    perf_exp[0] = 0; perf_exp[1] = 0; perf_exp[2] = 0; perf_exp[3] = 0;
`endif
    chk("perf_d_grants", 256'(perf_d_grants), 256'(perf_exp[0]));
    chk("perf_i_grants", 256'(perf_i_grants), 256'(perf_exp[1]));
    chk("perf_pf_grants", 256'(perf_pf_grants), 256'(perf_exp[2]));
    chk("perf_stall_cycles", 256'(perf_stall_cycles), 256'(perf_exp[3]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
